// File: rtl/num_cmp_checker_if.sv
// Compare-checker port bundle: sample/control inputs and sticky check results.
interface num_cmp_checker_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CYC_W    = 16
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      arm;
  logic                      clear;
  logic [1:0]                mode;
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] num_a;
  logic [CHANNELS*WIDTH-1:0] num_b;
  logic [CHANNELS-1:0]       ch_pass;
  logic                      busy;
  logic                      fail;
  logic [CH_W-1:0]           fail_chan;
  logic [WIDTH-1:0]          fail_a;
  logic [WIDTH-1:0]          fail_b;
  logic [CYC_W-1:0]          fail_idx;
  logic [CNT_W-1:0]          err_count;

  modport master (
    output arm, clear, mode, in_valid, num_a, num_b,
    input  ch_pass, busy, fail, fail_chan, fail_a, fail_b, fail_idx, err_count
  );

  modport slave (
    input  arm, clear, mode, in_valid, num_a, num_b,
    output ch_pass, busy, fail, fail_chan, fail_a, fail_b, fail_idx, err_count
  );
endinterface

// File: rtl/num_cmp_checker.sv
// Multi-channel compare-and-check monitor: per-channel pass, sticky first-failure
// capture and saturating mismatch count.
module num_cmp_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned TOL      = 1,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CYC_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  num_cmp_checker_if.slave bus
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PC_W = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FAIL} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CYC_W-1:0] sample_idx;

  logic [CHANNELS-1:0] pass_c;
  logic [CH_W-1:0]     first_c;
  logic [WIDTH-1:0]    first_a_c;
  logic [WIDTH-1:0]    first_b_c;
  logic [PC_W-1:0]     nfail_c;
  logic [WIDTH-1:0]    a_c;
  logic [WIDTH-1:0]    b_c;
  logic [WIDTH:0]      diff_c;
  logic                ok_c;
  logic [CNT_W:0]      err_sum_c;
  logic [CNT_W-1:0]    err_next_c;

  // Per-channel compare; scanning high to low leaves the lowest failing channel captured.
  always_comb begin
    pass_c    = '0;
    first_c   = '0;
    first_a_c = '0;
    first_b_c = '0;
    nfail_c   = '0;
    a_c       = '0;
    b_c       = '0;
    diff_c    = '0;
    ok_c      = 1'b0;
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      a_c    = bus.num_a[c*WIDTH +: WIDTH];
      b_c    = bus.num_b[c*WIDTH +: WIDTH];
      diff_c = (a_c >= b_c) ? ({1'b0, a_c} - {1'b0, b_c}) : ({1'b0, b_c} - {1'b0, a_c});
      case (mode_q)
        2'd1:    ok_c = (a_c[WIDTH-1] == b_c[WIDTH-1]);
        2'd2:    ok_c = (diff_c <= (WIDTH+1)'(TOL));
        default: ok_c = (a_c == b_c);
      endcase
      pass_c[c] = ok_c;
      if (!ok_c) begin
        first_c   = CH_W'(c);
        first_a_c = a_c;
        first_b_c = b_c;
        nfail_c   = nfail_c + PC_W'(1);
      end
    end
  end

  // Saturating accumulate of failing channel-samples.
  always_comb begin
    err_sum_c  = {1'b0, bus.err_count} + (CNT_W+1)'(nfail_c);
    err_next_c = err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state         <= IDLE;
      mode_q        <= '0;
      sample_idx    <= '0;
      bus.ch_pass   <= '0;
      bus.busy      <= 1'b0;
      bus.fail      <= 1'b0;
      bus.fail_chan <= '0;
      bus.fail_a    <= '0;
      bus.fail_b    <= '0;
      bus.fail_idx  <= '0;
      bus.err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            state      <= RUN;
            mode_q     <= bus.mode;
            sample_idx <= '0;
            bus.busy   <= 1'b1;
          end
        end
        RUN, FAIL: begin
          if (bus.in_valid) begin
            bus.ch_pass   <= pass_c;
            bus.err_count <= err_next_c;
            if (sample_idx != '1) sample_idx <= sample_idx + CYC_W'(1);
            // Capture only on the first failing sample; FAIL keeps counting.
            if (state == RUN && !(&pass_c)) begin
              state         <= FAIL;
              bus.fail      <= 1'b1;
              bus.fail_chan <= first_c;
              bus.fail_a    <= first_a_c;
              bus.fail_b    <= first_b_c;
              bus.fail_idx  <= sample_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_num_cmp_checker.sv
// Scoreboard bench for num_cmp_checker with directed, hand-computed vectors.
module tb_num_cmp_checker;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned TOL      = 1;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CYC_W    = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  num_cmp_checker_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .CYC_W(CYC_W)) bus ();

  num_cmp_checker #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .TOL(TOL), .CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [1:0]  pass;
    logic        fail;
    logic        chan;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] idx;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic        m_busy;
  logic        m_fail;
  logic        m_chan;
  logic [3:0]  m_a, m_b;
  logic [15:0] m_idx, m_sidx;
  logic [7:0]  m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_fail = 1'b0; m_chan = 1'b0;
    m_a = '0; m_b = '0; m_idx = '0; m_sidx = '0; m_cnt = '0;
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.arm = 1'b0; bus.clear = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic arm_t(input logic [1:0] md);
    @(negedge clk);
    bus.arm = 1'b1; bus.mode = md; bus.in_valid = 1'b0;
    @(negedge clk);
    bus.arm = 1'b0;
    if (!m_busy) begin
      m_busy = 1'b1;
      m_sidx = '0;
    end
  endtask

  task automatic clear_t();
    @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
  endtask

  // Issue one valid sample; ep is the hand-computed per-channel pass vector (bit 0 = ch0).
  task automatic sample(input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] ep);
    int sum;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.num_a = {a1, a0};
    bus.num_b = {b1, b0};
    sum = int'(m_cnt) + (ep[0] ? 0 : 1) + (ep[1] ? 0 : 1);
    m_cnt = (sum > 255) ? 8'd255 : 8'(sum);
    if (!m_fail && ep != 2'b11) begin
      m_fail = 1'b1;
      m_chan = ep[0] ? 1'b1 : 1'b0;
      m_a    = ep[0] ? a1 : a0;
      m_b    = ep[0] ? b1 : b0;
      m_idx  = m_sidx;
    end
    if (m_sidx != 16'hFFFF) m_sidx++;
    q.push_back('{pass: ep, fail: m_fail, chan: m_chan, a: m_a, b: m_b, idx: m_idx, cnt: m_cnt});
  endtask

  task automatic idle_t(input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.num_a = {a1, a0};
    bus.num_b = {b1, b0};
  endtask

  // Monitor: a valid sample seen at an edge produces an update checked just after it.
  initial begin : monitor
    logic v;
    exp_t e, act;
    forever begin
      @(posedge clk);
      v = bus.in_valid;
      #1;
      if (v && q.size() > 0) begin
        e   = q.pop_front();
        act = '{pass: bus.ch_pass, fail: bus.fail, chan: bus.fail_chan, a: bus.fail_a,
                b: bus.fail_b, idx: bus.fail_idx, cnt: bus.err_count};
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL sample: got pass=%b fail=%b chan=%0d a=%0d b=%0d idx=%0d cnt=%0d required pass=%b fail=%b chan=%0d a=%0d b=%0d idx=%0d cnt=%0d",
                   act.pass, act.fail, act.chan, act.a, act.b, act.idx, act.cnt,
                   e.pass, e.fail, e.chan, e.a, e.b, e.idx, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bus.arm = 1'b0; bus.clear = 1'b0; bus.mode = 2'd0;
    bus.in_valid = 1'b0; bus.num_a = '0; bus.num_b = '0;
    model_reset();
    do_reset();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_fail", 32'(bus.fail), 32'd0);
    check("reset_pass", 32'(bus.ch_pass), 32'd0);
    check("reset_cnt", 32'(bus.err_count), 32'd0);

    // Exact mode: 18 passing samples, idle mismatches, then a failure at sample 18.
    arm_t(2'd0);
    check("arm_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 18; i++) sample(4'd8, 4'd8, 4'd8, 4'd8, 2'b11);
    for (int i = 0; i < 3; i++) idle_t(4'd1, 4'd2, 4'd3, 4'd4);
    check("novalid_fail", 32'(bus.fail), 32'd0);
    check("novalid_cnt", 32'(bus.err_count), 32'd0);
    check("novalid_pass", 32'(bus.ch_pass), 32'd3);
    sample(4'd9, 4'd7, 4'd8, 4'd8, 2'b10);
    sample(4'd8, 4'd8, 4'd3, 4'd5, 2'b01);
    idle_t(4'd0, 4'd0, 4'd0, 4'd0);
    check("m0_fail_idx", 32'(bus.fail_idx), 32'd18);
    check("m0_fail_a", 32'(bus.fail_a), 32'd9);
    check("m0_fail_b", 32'(bus.fail_b), 32'd7);
    check("m0_cnt", 32'(bus.err_count), 32'd2);

    clear_t();
    check("clear_busy", 32'(bus.busy), 32'd0);
    check("clear_fail", 32'(bus.fail), 32'd0);
    check("clear_cnt", 32'(bus.err_count), 32'd0);
    check("clear_pass", 32'(bus.ch_pass), 32'd0);

    // MSB-only mode; a second arm while running must not re-latch exact mode.
    arm_t(2'd1);
    arm_t(2'd0);
    sample(4'd9, 4'd8, 4'd9, 4'd7, 2'b01);
    sample(4'd0, 4'd7, 4'd8, 4'd15, 2'b11);
    idle_t(4'd0, 4'd0, 4'd0, 4'd0);
    check("m1_fail_chan", 32'(bus.fail_chan), 32'd1);

    // Tolerance mode: boundary diff 1 passes, diff 2 and diff 15 fail.
    clear_t();
    arm_t(2'd2);
    sample(4'd8, 4'd9, 4'd9, 4'd8, 2'b11);
    sample(4'd7, 4'd9, 4'd0, 4'd15, 2'b00);
    sample(4'd15, 4'd0, 4'd5, 4'd5, 2'b10);
    idle_t(4'd0, 4'd0, 4'd0, 4'd0);
    check("m2_fail_idx", 32'(bus.fail_idx), 32'd1);

    // Mode 3 behaves as exact; 200 double mismatches saturate the counter.
    clear_t();
    arm_t(2'd3);
    for (int i = 0; i < 200; i++) sample(4'd1, 4'd2, 4'd3, 4'd4, 2'b00);
    idle_t(4'd0, 4'd0, 4'd0, 4'd0);
    check("sat_cnt", 32'(bus.err_count), 32'd255);
    check("sat_chan", 32'(bus.fail_chan), 32'd0);
    check("sat_idx", 32'(bus.fail_idx), 32'd0);

    // Reset while in FAIL.
    do_reset();
    check("rst_fail", 32'(bus.fail), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt", 32'(bus.err_count), 32'd0);
    check("rst_caps", {8'(bus.fail_a), 8'(bus.fail_b), 16'(bus.fail_idx)}, 32'd0);
    check("rst_pass", 32'(bus.ch_pass), 32'd0);

    // Clear beats arm in the same cycle.
    @(negedge clk);
    bus.arm = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0; bus.clear = 1'b0;
    @(negedge clk);
    check("armclear_busy", 32'(bus.busy), 32'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
